// File: rtl/mem_unit.sv
// mem_unit: single-outstanding memory access unit behind the address register.
// Services one read or write at a time against two internal word arrays (data and
// instruction memory), inserting a fixed number of wait states per access, and
// returns a registered read word plus a one-cycle completion pulse.
//
// Ports:
//   clk       system clock, all state updates on the rising edge
//   reset     synchronous, active-high reset
//   addr_in   access address (from AR)
//   data_in   write data from the processor bus
//   read_en   read request, sampled only while idle
//   write_en  write request, sampled only while idle
//   mem_sel   0 = data memory, 1 = instruction memory
//   prog_en   permits writes to instruction memory when 1
//   data_out  last successfully read word (registered)
//   busy      high while a request is in progress
//   done      one-cycle completion pulse
//   err       high with done when the request was rejected
module mem_unit #(
  parameter int unsigned reg_width   = 12,
  parameter int unsigned data_width  = 8,
  parameter int unsigned wait_cycles = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [reg_width-1:0]  addr_in,
  input  logic [data_width-1:0] data_in,
  input  logic                  read_en,
  input  logic                  write_en,
  input  logic                  mem_sel,
  input  logic                  prog_en,
  output logic [data_width-1:0] data_out,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  localparam int unsigned Depth = 2 ** reg_width;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [data_width-1:0] data_out_q, data_out_d;

  // Request captured at acceptance; inputs are don't-care while busy.
  logic [reg_width-1:0]  addr_q, addr_d;
  logic [data_width-1:0] wdata_q, wdata_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic                  sel_q, sel_d;
  logic                  prog_q, prog_d;

  logic [data_width-1:0] dmem [Depth];
  logic [data_width-1:0] imem [Depth];

  logic reject;
  logic access;
  logic do_write;
  logic do_read;

  // Conflicting enables, or an instruction-memory write without programming permission.
  assign reject   = (rd_q & wr_q) | (wr_q & sel_q & ~prog_q);
  assign do_write = access & wr_q & ~reject;
  assign do_read  = access & rd_q & ~reject;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    sel_d      = sel_q;
    prog_d     = prog_q;
    access     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (read_en || write_en) begin
          addr_d  = addr_in;
          wdata_d = data_in;
          rd_d    = read_en;
          wr_d    = write_en;
          sel_d   = mem_sel;
          prog_d  = prog_en;
          cnt_d   = 4'(wait_cycles);
          busy_d  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access  = 1'b1;
          done_d  = 1'b1;
          err_d   = reject;
          state_d = StResp;
        end
      end
      StResp: begin
        // The next request can be sampled on the edge after this one.
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    data_out_d = data_out_q;
    if (do_read) begin
      data_out_d = sel_q ? imem[addr_q] : dmem[addr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      data_out_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      sel_q      <= 1'b0;
      prog_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      data_out_q <= data_out_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      sel_q      <= sel_d;
      prog_q     <= prog_d;
    end
  end

  // Arrays are never cleared; reset on the access edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      if (sel_q) begin
        imem[addr_q] <= wdata_q;
      end else begin
        dmem[addr_q] <= wdata_q;
      end
    end
  end

  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
